// File: rtl/pkt_sender_pkg.sv
// Shared types and widths for the packet sender and its word FIFO.
package pkt_sender_pkg;

  localparam int unsigned AddrW       = 32;
  localparam int unsigned DataW       = 32;
  localparam int unsigned LenWDefault = 16;
  // Byte lane index inside a 32-bit word.
  localparam int unsigned ByteIdxW    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StDrain,
    StDone
  } state_e;

  // Number of whole words needed to cover len bytes.
  function automatic logic [31:0] words_for_len(input logic [31:0] len);
    return (len + 32'd3) >> 2;
  endfunction

endpackage

// File: rtl/pkt_fifo.sv
// Synchronous word FIFO; head entry is visible on rdata_o without a pop.
module pkt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [PtrW:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW + 1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign rdata_o = mem_q[rptr_q];
  // A push at full is accepted when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full_o || pop_i);
  assign do_pop  = pop_i && !empty_o;

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop) cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

endmodule

// File: rtl/pkt_sender.sv
// Memory-to-byte-stream engine: fetches words over a bus master port and
// streams them LSB first on a valid/ready byte interface.
module pkt_sender
  import pkt_sender_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_W      = LenWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [AddrW-1:0] base_addr_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  input  logic             mem_gnt_i,
  input  logic [DataW-1:0] mem_rdata_i,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [31:0]      id_o
);

  state_e                state_q, state_d;
  logic [AddrW-1:0]      addr_q, addr_d;
  logic [LEN_W-1:0]      bytes_left_q, bytes_left_d;
  logic [LEN_W-1:0]      words_left_q, words_left_d;
  logic [ByteIdxW-1:0]   idx_q, idx_d;
  logic [31:0]           id_q, id_d;

  logic                  active, tx_fire, final_byte;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DataW-1:0]      fifo_rdata;

  // The FIFO head doubles as the serialiser's current word, so a word being
  // streamed still occupies its FIFO slot until its last byte goes out.
  pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DataW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .wdata_i (mem_rdata_i),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign active     = (state_q == StFetch) || (state_q == StDrain);
  assign mem_req_o  = (state_q == StFetch) && (words_left_q != '0) && !fifo_full;
  assign mem_addr_o = addr_q;
  assign fifo_push  = mem_req_o && mem_gnt_i;
  assign tx_valid_o = active && !fifo_empty && (bytes_left_q != '0);
  assign tx_data_o  = fifo_rdata[{idx_q, 3'b000} +: 8];
  assign tx_fire    = tx_valid_o && tx_ready_i;
  assign final_byte = tx_fire && (bytes_left_q == LEN_W'(1));
  // Retire the word after lane 3 or after the last byte of the transfer.
  assign fifo_pop   = tx_fire && ((idx_q == 2'd3) || final_byte);
  assign busy_o     = (state_q != StIdle);
  assign ready_o    = (state_q == StDone);
  assign id_o       = id_q;

  // Next-state: command latch, fetch bookkeeping and serialiser counters.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    bytes_left_d = bytes_left_q;
    words_left_d = words_left_q;
    idx_d        = idx_q;
    id_d         = id_q;

    if (tx_fire) begin
      bytes_left_d = bytes_left_q - 1'b1;
      idx_d        = fifo_pop ? '0 : idx_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          addr_d       = {base_addr_i[AddrW-1:2], 2'b00};
          bytes_left_d = len_i;
          words_left_d = LEN_W'(words_for_len(32'(len_i)));
          idx_d        = '0;
          if (len_i == '0) begin
            state_d = StDone;
            id_d    = id_q + 1'b1;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StFetch: begin
        if (fifo_push) begin
          addr_d       = addr_q + 32'd4;
          words_left_d = words_left_q - 1'b1;
          if (words_left_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (final_byte) begin
          state_d = StDone;
          id_d    = id_q + 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      bytes_left_q <= '0;
      words_left_q <= '0;
      idx_q        <= '0;
      id_q         <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      bytes_left_q <= bytes_left_d;
      words_left_q <= words_left_d;
      idx_q        <= idx_d;
      id_q         <= id_d;
    end
  end

endmodule

// File: tb/tb_pkt_sender.sv
// Directed bench for pkt_sender with a queue-based reference of reads and bytes.
module tb_pkt_sender;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [15:0] len = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        gnt = 1'b0;
  logic [31:0] mem_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        busy;
  logic        ready;
  logic [31:0] id;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ready_cnt = 0;
  logic [31:0] exp_id = '0;

  logic [31:0] exp_addr [$];
  logic [7:0]  exp_byte [$];
  logic [31:0] got_addr [$];
  logic [7:0]  got_byte [$];
  int          got_cyc  [$];

  logic [7:0] t1_bytes [8] = '{8'h1E, 8'h0F, 8'hC3, 8'hB5, 8'h1A, 8'h0F, 8'hC3, 8'hB5};
  logic [7:0] t2_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  pkt_sender #(
    .FIFO_DEPTH (4),
    .LEN_W      (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start),
    .base_addr_i (base),
    .len_i       (len),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_gnt_i   (gnt),
    .mem_rdata_i (mem_rdata),
    .tx_data_o   (tx_data),
    .tx_valid_o  (tx_valid),
    .tx_ready_i  (tx_ready),
    .busy_o      (busy),
    .ready_o     (ready),
    .id_o        (id)
  );

  always #5 clk = ~clk;

  // Memory image: two pinned words, everything else derived from the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h2000_0000) return 32'h4433_2211;
    if (a == 32'h2000_0004) return 32'h8877_6655;
    return a ^ 32'hA5C3_0F1E;
  endfunction

  assign mem_rdata = mem_word(mem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the reads and bytes a transfer must produce, from addr/len alone.
  task automatic plan(input logic [31:0] b, input int n);
    logic [31:0] a, w;
    a = {b[31:2], 2'b00};
    for (int k = 0; k < (n + 3) / 4; k++) exp_addr.push_back(a + 32'(4 * k));
    for (int i = 0; i < n; i++) begin
      w = mem_word(a + 32'(4 * (i / 4)));
      exp_byte.push_back(w[8 * (i % 4) +: 8]);
    end
  endtask

  task automatic do_start(input logic [31:0] b, input int n);
    got_addr.delete();
    got_byte.delete();
    got_cyc.delete();
    plan(b, n);
    base  = b;
    len   = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit wiggle);
    bit seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      if (wiggle) begin
        gnt      = (k % 3 != 1);
        tx_ready = (k % 4 != 2);
      end
      tick();
      if (ready) seen = 1'b1;
    end
    chk("done_within_budget", 32'(seen), 32'd1);
    gnt      = 1'b1;
    tx_ready = 1'b1;
    tick();
    chk("busy_after_done", 32'(busy), 32'd0);
    chk("ready_single_cycle", 32'(ready), 32'd0);
  endtask

  // Per-cycle compare against the reference queues plus handshake stability.
  initial begin
    bit          req_hold = 1'b0, tx_hold = 1'b0;
    logic [31:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        req_hold = 1'b0;
        tx_hold  = 1'b0;
      end else begin
        if (req_hold) begin
          chk("req_stable", 32'(mem_req), 32'd1);
          chk("addr_stable", mem_addr, hold_addr);
        end
        if (tx_hold) begin
          chk("valid_stable", 32'(tx_valid), 32'd1);
          chk("data_stable", 32'(tx_data), 32'(hold_data));
        end
        if (mem_req) chk("req_only_when_busy", 32'(busy), 32'd1);
        if (mem_req && gnt) begin
          got_addr.push_back(mem_addr);
          if (exp_addr.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_read: got 0x%08h, expected no read", mem_addr);
          end else chk("read_addr", mem_addr, exp_addr.pop_front());
        end
        if (tx_valid && tx_ready) begin
          got_byte.push_back(tx_data);
          got_cyc.push_back(cyc);
          if (exp_byte.size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%02h, expected no byte", tx_data);
          end else chk("tx_byte", 32'(tx_data), 32'(exp_byte.pop_front()));
        end
        if (ready) begin
          chk("done_reads_left", 32'(exp_addr.size()), 32'd0);
          chk("done_bytes_left", 32'(exp_byte.size()), 32'd0);
          exp_id++;
          chk("id_on_done", id, exp_id);
          ready_cnt++;
        end
        req_hold  = mem_req && !gnt;
        hold_addr = mem_addr;
        tx_hold   = tx_valid && !tx_ready;
        hold_data = tx_data;
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values.
    #3;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_id", id, 32'd0);
    tick();
    rst = 1'b1;
    tick();

    // Unaligned base, two words, full throughput.
    gnt      = 1'b1;
    tx_ready = 1'b1;
    do_start(32'h1000_0002, 8);
    chk("t1_busy_n1", 32'(busy), 32'd1);
    chk("t1_req_n1", 32'(mem_req), 32'd1);
    chk("t1_addr_n1", mem_addr, 32'h1000_0000);
    wait_done(40, 1'b0);
    chk("t1_nreads", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() == 2) begin
      chk("t1_read0", got_addr[0], 32'h1000_0000);
      chk("t1_read1", got_addr[1], 32'h1000_0004);
    end
    chk("t1_nbytes", 32'(got_byte.size()), 32'd8);
    for (int i = 0; i < 8 && i < got_byte.size(); i++)
      chk("t1_byte_literal", 32'(got_byte[i]), 32'(t1_bytes[i]));
    if (got_cyc.size() == 8) chk("t1_back_to_back", 32'(got_cyc[7] - got_cyc[0]), 32'd7);
    chk("t1_id", id, 32'd1);
    chk("t1_ready_cnt", 32'(ready_cnt), 32'd1);

    // Partial last word: trailing lanes must be dropped.
    do_start(32'h2000_0000, 5);
    wait_done(40, 1'b0);
    chk("t2_nbytes", 32'(got_byte.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_byte.size(); i++)
      chk("t2_byte_literal", 32'(got_byte[i]), 32'(t2_bytes[i]));
    chk("t2_id", id, 32'd2);

    // Zero length: done pulse on the next cycle, no bus traffic.
    do_start(32'h0000_1230, 0);
    chk("t3_ready_n1", 32'(ready), 32'd1);
    chk("t3_busy_n1", 32'(busy), 32'd1);
    chk("t3_no_req", 32'(mem_req), 32'd0);
    chk("t3_id", id, 32'd3);
    tick();
    chk("t3_busy_n2", 32'(busy), 32'd0);
    chk("t3_ready_n2", 32'(ready), 32'd0);
    chk("t3_nreads", 32'(got_addr.size()), 32'd0);

    // Sink stalled: FIFO fills after four grants, then the stream resumes.
    tx_ready = 1'b0;
    do_start(32'h3000_0000, 64);
    repeat (20) tick();
    chk("t4_grants_at_full", 32'(got_addr.size()), 32'd4);
    chk("t4_req_low_full", 32'(mem_req), 32'd0);
    chk("t4_valid_held", 32'(tx_valid), 32'd1);
    chk("t4_head_byte", 32'(tx_data), 32'h1E);
    tx_ready = 1'b1;
    wait_done(200, 1'b0);
    chk("t4_nbytes", 32'(got_byte.size()), 32'd64);
    chk("t4_nreads", 32'(got_addr.size()), 32'd16);

    // Second start while busy is ignored.
    do_start(32'h4000_0000, 10);
    repeat (2) tick();
    base  = 32'h5000_0000;
    len   = 16'd20;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(60, 1'b0);
    repeat (20) tick();
    chk("t5_nbytes", 32'(got_byte.size()), 32'd10);
    chk("t5_ready_cnt", 32'(ready_cnt), 32'd5);
    chk("t5_idle", 32'(busy), 32'd0);

    // Irregular grant and sink back-pressure.
    do_start(32'h6000_0001, 13);
    wait_done(200, 1'b1);
    chk("t7_nbytes", 32'(got_byte.size()), 32'd13);
    chk("t7_nreads", 32'(got_addr.size()), 32'd4);
    chk("t7_id", id, 32'd6);

    // Reset mid-fetch, then a fresh transfer across the address wrap.
    gnt      = 1'b0;
    tx_ready = 1'b0;
    do_start(32'hFFFF_FFFC, 8);
    gnt = 1'b1;
    tick();
    gnt = 1'b0;
    tick();
    chk("t6_busy_before_rst", 32'(busy), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
    chk("t6_rst_mem_addr", mem_addr, 32'd0);
    chk("t6_rst_tx_data", 32'(tx_data), 32'd0);
    chk("t6_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(ready), 32'd0);
    chk("t6_rst_id", id, 32'd0);
    exp_addr.delete();
    exp_byte.delete();
    exp_id = '0;
    tick();
    rst      = 1'b1;
    gnt      = 1'b1;
    tx_ready = 1'b1;
    tick();
    chk("t6_no_done_after_rst", 32'(ready_cnt), 32'd6);
    do_start(32'hFFFF_FFFC, 8);
    wait_done(40, 1'b0);
    chk("t6_nreads", 32'(got_addr.size()), 32'd2);
    if (got_addr.size() == 2) begin
      chk("t6_read0", got_addr[0], 32'hFFFF_FFFC);
      chk("t6_read1_wrap", got_addr[1], 32'h0000_0000);
    end
    chk("t6_nbytes", 32'(got_byte.size()), 32'd8);
    chk("t6_id", id, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_sender.md
# pkt_sender

Memory-to-byte-stream transfer engine beside the tinyriscv core's execute stage. It consumes the start/address/length command the execute stage issues and reads the buffer word by word over its own bus master port. It buffers the words in a small FIFO and serialises them, least-significant byte first, onto a valid/ready byte stream toward the UART/link peripheral. Status (busy, done pulse, transfer ID) goes back to the execute stage, which stalls the pipeline while the engine is busy.

## Interface
Parameters:
- FIFO_DEPTH, 4: word FIFO entries; power of two, at least 2.
- LEN_W, 16: width of the byte-length field.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle command pulse from the execute stage.
- base_addr_i  in  32  buffer start address; bits [1:0] are ignored (word aligned).
- len_i  in  LEN_W  transfer length in bytes.
- mem_req_o  out  1  bus read request.
- mem_addr_o  out  32  bus read address.
- mem_gnt_i  in  1  grant; mem_rdata_i is valid in the same cycle.
- mem_rdata_i  in  32  read data.
- tx_data_o  out  8  stream byte.
- tx_valid_o  out  1  stream byte valid.
- tx_ready_i  in  1  sink accepts the byte.
- busy_o  out  1  transfer in progress.
- ready_o  out  1  one-cycle done pulse.
- id_o  out  32  count of completed transfers.

## Operation
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE, start_i=1:
  - Latch addr = {base_addr_i[31:2],2'b00}, bytes_left = len_i, words_left = ceil(len_i/4).
  - If len_i=0, go to DONE. Otherwise go to FETCH.
- start_i while not IDLE is ignored; there is no queueing.
- FETCH:
  - mem_req_o=1 whenever words_left>0 and the FIFO is not full.
  - On mem_gnt_i: push mem_rdata_i, addr+=4 (wraps modulo 2^32), words_left-=1.
  - When words_left reaches 0, go to DRAIN.
- Serialiser runs in FETCH and DRAIN:
  - Holds the current word and byte index 0..3.
  - Presents byte[idx] with tx_valid_o=1 while bytes_left>0 and a word is loaded.
  - On tx_valid_o & tx_ready_i: bytes_left-=1 and idx+=1.
  - After idx 3, or after the final byte, it pops the next FIFO word.
  - Bytes beyond len in the last word are discarded and never presented.
- DRAIN, bytes_left=0 and the last byte has been accepted: go to DONE.
- DONE (one cycle): ready_o=1, id_o+=1 (wraps), then IDLE.
- busy_o=1 in FETCH, DRAIN and DONE. It is 0 only in IDLE.
- mem_req_o is never asserted outside FETCH, and never when the FIFO is full.
- Simultaneous FIFO push and pop in the same cycle are both honoured, including at full.
- Asynchronous reset mid-transfer: immediate return to IDLE, FIFO emptied, id_o=0. The partial transfer is lost and there is no done pulse.

## Timing
- Reset values: mem_req_o=0, mem_addr_o=0, tx_data_o=0, tx_valid_o=0, busy_o=0, ready_o=0, id_o=0.
- start_i sampled at edge N: busy_o=1 and mem_req_o=1 from cycle N+1 (len>0).
- Read latency: word pushed at the edge where mem_gnt_i=1. Its first byte is on tx_data_o no earlier than the following cycle (registered output).
- Stream throughput with tx_ready_i held high and grant every cycle: 1 byte/cycle sustained.
- mem_req_o and mem_addr_o are stable until granted.
- tx_data_o and tx_valid_o are stable until accepted.
- len_i=0: ready_o pulses at N+1 with busy_o=1 for that single cycle; no bus request.
- ready_o and the id_o increment occur in the cycle after the final byte handshake. busy_o falls the cycle after ready_o.

## Structure
- Shared package (pkt_sender_pkg): state enum {IDLE, FETCH, DRAIN, DONE} and byte/word-count width helpers. The LEN_W default lives there alongside the defines.v bus widths.
- Sub-module pkt_fifo: synchronous FIFO, width 32, depth FIFO_DEPTH, with push, pop, full, empty, and flops reset by rst.
- The FSM, address/count registers and serialiser are in the top module.

## Test plan
- base=0x1000_0002, len=8, grant every cycle, tx_ready=1 -> reads at 0x1000_0000 and 0x1000_0004 only. Bytes are each word's little-endian bytes in order. ready_o pulses once and id_o goes 0→1.
- len=5, words 0x44332211 and 0x88776655 -> stream 11 22 33 44 55 exactly, with no 66/77/88.
- len=0 -> no mem_req_o; ready_o at N+1; id_o increments.
- tx_ready_i=0 for 20 cycles, FIFO_DEPTH=4, len=64 -> exactly 4 grants then mem_req_o=0. The stream resumes without loss when ready returns.
- start_i pulsed again mid-transfer -> ignored; only one ready_o; byte count matches the first len.
- rst low mid-FETCH with base=0xFFFF_FFFC, len=8 -> all outputs go to reset values immediately. A fresh len=8 transfer from 0xFFFF_FFFC then reads 0xFFFF_FFFC and 0x0000_0000 (address wrap).
